switch_nport: RTL and testbench
===============================

# switch_nport

Parametrised N-port packet switch, the next generation of the two-port `switch`. Each packet arrives on a single ingress port as an address/data word. The address upper bits select one of NUM_PORTS egress ports, and the packet is buffered in that port's FIFO. Each egress port drains independently under a valid/ready handshake. An all-ones address broadcasts to every port. The block sits between the stimulus/ingress interface and per-port consumers.

## Interface
Parameters:
- ADDR_W, 8, address width; must satisfy ADDR_W ≥ log2(NUM_PORTS)
- DATA_W, 16, data width
- NUM_PORTS, 4, egress port count; power of two, 2..16
- FIFO_DEPTH, 4, entries per egress FIFO; power of two, ≥2

Ports:
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- vld  in  1  ingress packet valid
- rdy  out  1  ingress ready (combinational)
- addr  in  ADDR_W  ingress address
- data  in  DATA_W  ingress data
- out_vld  out  NUM_PORTS  per-port head-of-FIFO valid
- out_rdy  in  NUM_PORTS  per-port consumer ready
- out_addr  out  NUM_PORTS*ADDR_W  per-port head address; port i occupies bits [i*ADDR_W +: ADDR_W]
- out_data  out  NUM_PORTS*DATA_W  per-port head data; same packing as out_addr
- pkt_cnt  out  NUM_PORTS*16  per-port accepted-packet counters (only with SWITCH_NPORT_STATS_EN)

## Operation
- Port select `sel` = addr[ADDR_W-1 -: log2(NUM_PORTS)].
- Broadcast: addr equal to all ones takes priority over `sel` and targets all ports.
- rdy:
  - unicast: rdy = !full[sel]
  - broadcast: rdy = no FIFO full
  - rdy is computed from current occupancy only; a same-cycle pop does not raise it.
- Push: when vld && rdy, the {addr, data} pair is written into the target FIFO(s); a broadcast writes identical entries to all ports in the same cycle.
- vld && !rdy: nothing is written; the sender must hold addr/data stable until accepted.
- Pop: on port i, out_vld[i] && out_rdy[i] advances that FIFO's read pointer. Ports are fully independent; no ordering between ports.
- Each FIFO uses read/write pointers of log2(FIFO_DEPTH)+1 bits. Pointers wrap modulo 2*FIFO_DEPTH.
  - full: MSBs differ and the rest of the bits are equal
  - empty: pointers equal
- Push and pop in the same cycle on one port (not full): occupancy is unchanged and both pointers advance.
- out_addr/out_data present the FIFO head, i.e. entry mem[rd_ptr]; they are undefined while out_vld[i] = 0, except all-zero after reset.
- Reset (async, any time including mid-transfer):
  - all pointers and storage cleared, so all FIFOs are empty
  - out_vld = 0, out_addr = 0, out_data = 0, pkt_cnt = 0
  - rdy = 1 once rstn is high, since all FIFOs are empty
- No state machine beyond the per-port FIFO pointers; each port is either empty, partially filled or full.

## Timing
- Ingress-to-egress latency: 1 cycle. A packet accepted at edge N gives out_vld = 1 after edge N, with no bubble.
- Full throughput: one packet accepted per cycle on ingress; one packet drained per port per cycle.
- out_vld[i] deasserts the cycle after the last entry is popped, unless a push to port i happened on that same edge.
- rdy is combinational on addr and the occupancy registers; out_* are driven by registers only.

## Configuration
- SWITCH_NPORT_STATS_EN defined:
  - 16-bit pkt_cnt[i] increments on each push to port i; a broadcast increments all ports.
  - Counters wrap 0xFFFF → 0x0000 and are cleared by reset.
- SWITCH_NPORT_STATS_EN undefined: the pkt_cnt port and its counters are absent; all other behaviour is identical.

## Test plan
Defaults apply: 4 ports, depth 4, sel = addr[7:6].
- Reset, then drive addr=0x45, data=0x1234 for 1 cycle with all out_rdy=1 → out_vld=4'b0010 and out_data[1]=0x1234 for exactly one cycle, starting 1 cycle after acceptance.
- out_rdy[2]=0; push 5 packets to addr 0x80 → first 4 accepted; rdy=0 on the 5th until out_rdy[2] is raised; order of output data is preserved.
- Broadcast addr=0xFF, data=0xBEEF with port 3 full → rdy=0. Pop one from port 3 → broadcast is accepted; all four out_vld high with out_data=0xBEEF.
- Simultaneous push and pop on port 0 at occupancy 2 for 10 cycles → occupancy stays 2 and data emerges in FIFO order; exercises pointer wrap past 2*DEPTH.
- Assert rstn=0 mid-burst with ports 0 and 2 non-empty → out_vld=0 immediately (asynchronous); after release, rdy=1 and no stale packets appear.
- With SWITCH_NPORT_STATS_EN: 3 unicast pushes to port 1 plus 2 broadcasts → pkt_cnt = {2, 2, 5, 2} for ports {3, 2, 1, 0}.

Source files
------------

// File: rtl/switch_nport_if.sv
// Bus bundle for switch_nport: ingress handshake plus per-port egress
// handshakes. The packet source and consumers use the master side and the
// switch uses the slave side.
interface switch_nport_if #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int NUM_PORTS = 4
);
  logic                        vld;
  logic                        rdy;
  logic [ADDR_W-1:0]           addr;
  logic [DATA_W-1:0]           data;
  logic [NUM_PORTS-1:0]        out_vld;
  logic [NUM_PORTS-1:0]        out_rdy;
  logic [NUM_PORTS*ADDR_W-1:0] out_addr;
  logic [NUM_PORTS*DATA_W-1:0] out_data;

  modport master (
    output vld, addr, data, out_rdy,
    input  rdy, out_vld, out_addr, out_data
  );

  modport slave (
    input  vld, addr, data, out_rdy,
    output rdy, out_vld, out_addr, out_data
  );
endinterface

// File: rtl/switch_nport.sv
// switch_nport: N-port address-routed packet switch with one FIFO per egress
// port. The top address bits select the port, and an all-ones address is
// broadcast to every port. The optional per-port accepted-packet counters
// (pkt_cnt) are built only when SWITCH_NPORT_STATS_EN is defined.
module switch_nport #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
`ifdef SWITCH_NPORT_STATS_EN
  output logic [NUM_PORTS*16-1:0] pkt_cnt,
`endif
  switch_nport_if.slave           bus
);

  localparam int SEL_W = $clog2(NUM_PORTS);
  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  logic [SEL_W-1:0]     sel;
  logic                 bcast;
  logic                 acc;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;

  assign sel   = bus.addr[ADDR_W-1 -: SEL_W];
  assign bcast = &bus.addr;

  // Ingress ready uses current occupancy only, so a pop in this cycle does
  // not open a slot until the next cycle.
  always_comb begin
    bus.rdy = 1'b0;
    if (bcast) bus.rdy = ~|full;
    else       bus.rdy = ~full[sel];
  end

  assign acc = bus.vld & bus.rdy;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [ENT_W-1:0] head;

    // Pointers carry one extra wrap bit to tell full apart from empty.
    assign full[i]  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                      (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign empty[i] = (wr_ptr == rd_ptr);
    assign push[i]  = acc && (bcast || (sel == SEL_W'(i)));
    assign pop[i]   = ~empty[i] & bus.out_rdy[i];

    // FIFO storage and pointers; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
      end else begin
        if (push[i]) begin
          mem[wr_ptr[IDX_W-1:0]] <= {bus.addr, bus.data};
          wr_ptr                 <= wr_ptr + 1'b1;
        end
        if (pop[i]) rd_ptr <= rd_ptr + 1'b1;
      end
    end

    assign head                             = mem[rd_ptr[IDX_W-1:0]];
    assign bus.out_vld[i]                   = ~empty[i];
    assign bus.out_addr[i*ADDR_W +: ADDR_W] = head[ENT_W-1 -: ADDR_W];
    assign bus.out_data[i*DATA_W +: DATA_W] = head[DATA_W-1:0];

`ifdef SWITCH_NPORT_STATS_EN
    logic [15:0] cnt;

    // Accepted-packet counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)        cnt <= '0;
      else if (push[i]) cnt <= cnt + 16'd1;
    end

    assign pkt_cnt[i*16 +: 16] = cnt;
`endif
  end

endmodule

// File: tb/tb_switch_nport.sv
// Self-checking bench for switch_nport at default parameters (4 ports,
// depth 4). A queue-per-port model predicts rdy, out_vld and head contents.
module tb_switch_nport;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int NP = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  switch_nport_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_PORTS(NP)) bus ();

`ifdef SWITCH_NPORT_STATS_EN
  logic [NP*16-1:0] pkt_cnt;
`endif

  switch_nport #(.ADDR_W(AW), .DATA_W(DW), .NUM_PORTS(NP), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rstn    (rstn),
`ifdef SWITCH_NPORT_STATS_EN
    .pkt_cnt (pkt_cnt),
`endif
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW+DW-1:0] q [NP][$];
  logic [15:0]      exp_cnt [NP];

  task automatic model_clear();
    for (int p = 0; p < NP; p++) begin
      q[p].delete();
      exp_cnt[p] = '0;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.vld = 1'b0; bus.addr = '0; bus.data = '0; bus.out_rdy = '0;
    model_clear();
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  // One clock cycle: drive, check against the model, clock, update the model.
  task automatic cycle(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [NP-1:0] ordy, output logic acc);
    logic          exp_rdy;
    logic [NP-1:0] exp_vld;
    logic          bc;
    int            s;
    bus.vld = v; bus.addr = a; bus.data = d; bus.out_rdy = ordy;
    #1;
    bc = (a == 8'hFF);
    s  = int'(a[7:6]);
    if (bc) begin
      exp_rdy = 1'b1;
      for (int p = 0; p < NP; p++) if (q[p].size() >= DEPTH) exp_rdy = 1'b0;
    end else begin
      exp_rdy = (q[s].size() < DEPTH);
    end
    n_checks++;
    if (bus.rdy !== exp_rdy) begin
      n_fail++;
      $display("FAIL rdy @%0t: got %b expected %b (addr %h)", $time, bus.rdy, exp_rdy, a);
    end
    for (int p = 0; p < NP; p++) exp_vld[p] = (q[p].size() > 0);
    n_checks++;
    if (bus.out_vld !== exp_vld) begin
      n_fail++;
      $display("FAIL out_vld @%0t: got %b expected %b", $time, bus.out_vld, exp_vld);
    end
    for (int p = 0; p < NP; p++) begin
      if (q[p].size() > 0) begin
        n_checks++;
        if ({bus.out_addr[p*AW +: AW], bus.out_data[p*DW +: DW]} !== q[p][0]) begin
          n_fail++;
          $display("FAIL head port%0d @%0t: got %h/%h expected %h", p, $time,
                   bus.out_addr[p*AW +: AW], bus.out_data[p*DW +: DW], q[p][0]);
        end
      end
    end
    acc = v && exp_rdy;
    @(posedge clk); #1;
    for (int p = 0; p < NP; p++)
      if (exp_vld[p] && ordy[p]) void'(q[p].pop_front());
    if (acc) begin
      for (int p = 0; p < NP; p++) begin
        if (bc || p == s) begin
          q[p].push_back({a, d});
          exp_cnt[p] = exp_cnt[p] + 16'd1;
        end
      end
    end
  endtask

  task automatic idle(input int n, input logic [NP-1:0] ordy);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 16'h0000, ordy, acc);
  endtask

  // Holds a packet until accepted, with a cycle budget.
  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NP-1:0] ordy);
    logic acc;
    int   tries = 0;
    acc = 1'b0;
    while (!acc && tries < 50) begin
      cycle(1'b1, a, d, ordy, acc);
      tries++;
    end
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL send_timeout: addr %h not accepted after %0d cycles", a, tries);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.out_vld !== 4'b0000 || bus.out_addr !== '0 || bus.out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got vld %b addr %h data %h expected all zero",
               bus.out_vld, bus.out_addr, bus.out_data);
    end
    n_checks++;
    if (bus.rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rdy: got %b expected 1", bus.rdy);
    end
`ifdef SWITCH_NPORT_STATS_EN
    n_checks++;
    if (pkt_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_pkt_cnt: got %h expected 0", pkt_cnt);
    end
`endif
  endtask

  task automatic test_unicast();
    logic acc;
    cycle(1'b1, 8'h45, 16'h1234, 4'hF, acc);
    n_checks++;
    if (bus.out_vld !== 4'b0010 || bus.out_data[16 +: 16] !== 16'h1234) begin
      n_fail++;
      $display("FAIL unicast_out: got vld %b data1 %h expected 0010 / 1234",
               bus.out_vld, bus.out_data[16 +: 16]);
    end
    idle(3, 4'hF);
  endtask

  task automatic test_backpressure();
    logic acc;
    for (int k = 0; k < DEPTH; k++) cycle(1'b1, 8'h80, 16'hA000 + 16'(k), 4'b1011, acc);
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'h80, 16'hA004, 4'b1011, acc);
    n_checks++;
    if (acc !== 1'b0 || q[2].size() != DEPTH) begin
      n_fail++;
      $display("FAIL backpressure_fifth: got accepted %b occ %0d expected 0 / %0d",
               acc, q[2].size(), DEPTH);
    end
    send(8'h80, 16'hA004, 4'hF);
    idle(8, 4'hF);
  endtask

  task automatic test_broadcast();
    logic acc;
    for (int k = 0; k < DEPTH; k++) send(8'hC0, 16'h3000 + 16'(k), 4'b0000);
    for (int k = 0; k < 2; k++) cycle(1'b1, 8'hFF, 16'hBEEF, 4'b0000, acc);
    n_checks++;
    if (acc !== 1'b0) begin
      n_fail++;
      $display("FAIL bcast_blocked: got accepted %b expected 0", acc);
    end
    cycle(1'b1, 8'hFF, 16'hBEEF, 4'b1000, acc);
    cycle(1'b1, 8'hFF, 16'hBEEF, 4'b0000, acc);
    n_checks++;
    if (acc !== 1'b1 || bus.out_vld !== 4'b1111 || bus.out_data[15:0] !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL bcast_accept: got acc %b vld %b data0 %h expected 1 / 1111 / beef",
               acc, bus.out_vld, bus.out_data[15:0]);
    end
    idle(10, 4'hF);
  endtask

  task automatic test_push_pop();
    logic acc;
    send(8'h01, 16'h5000, 4'b0000);
    send(8'h02, 16'h5001, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 8'h10 + 8'(k), 16'h5002 + 16'(k), 4'b0001, acc);
      n_checks++;
      if (q[0].size() != 2 || bus.out_vld[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL push_pop_occ: got occ %0d vld %b expected 2 / 1", q[0].size(), bus.out_vld[0]);
      end
    end
    idle(4, 4'hF);
  endtask

  task automatic test_reset_mid();
    logic acc;
    send(8'h00, 16'h7000, 4'b0000);
    send(8'h80, 16'h7001, 4'b0000);
    send(8'h05, 16'h7002, 4'b0000);
    #3;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (bus.out_vld !== 4'b0000 || bus.rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async: got vld %b rdy %b expected 0000 / 1", bus.out_vld, bus.rdy);
    end
    model_clear();
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(3, 4'hF);
  endtask

  task automatic test_random();
    logic          acc, v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [NP-1:0] ordy;
    acc = 1'b1; v = 1'b0; a = '0; d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!(v && !acc)) begin
        v = ($urandom_range(0, 3) != 0);
        a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
        d = 16'($urandom);
      end
      for (int p = 0; p < NP; p++) ordy[p] = ($urandom_range(0, 9) < 6);
      cycle(v, a, d, ordy, acc);
    end
    idle(12, 4'hF);
  endtask

`ifdef SWITCH_NPORT_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int k = 0; k < 3; k++) send(8'h40, 16'h0100 + 16'(k), 4'hF);
    for (int k = 0; k < 2; k++) send(8'hFF, 16'h0200 + 16'(k), 4'hF);
    idle(2, 4'hF);
    n_checks++;
    if (pkt_cnt !== {16'd2, 16'd2, 16'd5, 16'd2}) begin
      n_fail++;
      $display("FAIL pkt_cnt: got %h expected 0002000200050002", pkt_cnt);
    end
    for (int p = 0; p < NP; p++) begin
      n_checks++;
      if (pkt_cnt[p*16 +: 16] !== exp_cnt[p]) begin
        n_fail++;
        $display("FAIL pkt_cnt_model port%0d: got %0d expected %0d", p, pkt_cnt[p*16 +: 16], exp_cnt[p]);
      end
    end
  endtask
`endif

  initial begin
    bus.vld = 1'b0; bus.addr = '0; bus.data = '0; bus.out_rdy = '0;
    test_reset();
    test_unicast();
    test_backpressure();
    test_broadcast();
    test_push_pop();
    test_reset_mid();
    test_random();
`ifdef SWITCH_NPORT_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
